// File: rtl/neo_outlatch.sv
// neo_outlatch: clock-synchronous 68k output-register latch.
// Resynchronises the asynchronous write strobe, rejects short lows with a
// low-time filter and writes one of 2**ADDR_W registers once per accepted low.
// Each register is either latched or self-reverting after PULSE_CYCLES clocks.
//
// Ports:
//   CLK_24M    in   sole clock, rising edge
//   RESET      in   synchronous, active-high reset
//   nBITWD     in   asynchronous write strobe, active low
//   M68K_ADDR  in   register select, stable while nBITWD is low
//   M68K_DATA  in   write data, stable while nBITWD is low
//   REG_OUT    out  register contents, register k at [k*DATA_W +: DATA_W]
//   WR_PULSE   out  one-clock pulse on bit k after register k is written
//   PULSE_ACT  out  bit k high while register k's revert counter is non-zero
module neo_outlatch #(
   parameter int unsigned       DATA_W       = 6,
   parameter int unsigned       ADDR_W       = 1,
   parameter int unsigned       SYNC_STAGES  = 2,
   parameter int unsigned       MIN_LOW      = 2,
   parameter int unsigned       PULSE_CYCLES = 0,
   parameter logic [DATA_W-1:0] RESET_VAL    = '0
) (
   input  logic                             CLK_24M,
   input  logic                             RESET,
   input  logic                             nBITWD,
   input  logic [ADDR_W-1:0]                M68K_ADDR,
   input  logic [DATA_W-1:0]                M68K_DATA,
   output logic [(2**ADDR_W)*DATA_W-1:0]    REG_OUT,
   output logic [(2**ADDR_W)-1:0]           WR_PULSE,
   output logic [(2**ADDR_W)-1:0]           PULSE_ACT
);

   localparam int unsigned NREG  = 2**ADDR_W;
   localparam int unsigned CNT_W = (PULSE_CYCLES > 0) ? $clog2(PULSE_CYCLES + 1) : 1;
   localparam int unsigned LOW_W = $clog2(MIN_LOW + 1);

   typedef enum logic [1:0] {
      WAIT_HIGH = 2'd0,
      ARMED     = 2'd1,
      LOW_CNT   = 2'd2,
      FIRED     = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] vld_q;
   logic                   s_n;
   logic                   s_vld;
   state_t                 state_q;
   logic [LOW_W-1:0]       low_cnt_q;
   logic                   fire_c;
   logic [NREG-1:0]        wr_c;
   logic [CNT_W-1:0]       cnt_q   [NREG];
   logic [CNT_W-1:0]       cnt_nxt [NREG];

   // Strobe synchroniser; vld_q tracks which stages hold real samples rather
   // than the forced-high reset value, so a strobe already low at reset
   // release is not mistaken for a fresh high-to-low transition.
   always_ff @(posedge CLK_24M) begin
      if (RESET) begin
         sync_q <= '1;
         vld_q  <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], nBITWD};
         vld_q  <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign s_n   = sync_q[SYNC_STAGES-1];
   assign s_vld = vld_q[SYNC_STAGES-1];

   // Write fires on the edge that completes MIN_LOW synchronised low samples.
   always_comb begin
      fire_c = 1'b0;
      if (!s_n) begin
         case (state_q)
            ARMED:   fire_c = (MIN_LOW == 32'd1);
            LOW_CNT: fire_c = ((32'(low_cnt_q) + 32'd1) >= MIN_LOW);
            default: fire_c = 1'b0;
         endcase
      end
   end

   // Strobe FSM: one write per low period, short lows rejected.
   always_ff @(posedge CLK_24M) begin
      if (RESET) begin
         state_q   <= WAIT_HIGH;
         low_cnt_q <= '0;
      end else begin
         case (state_q)
            WAIT_HIGH: begin
               if (s_vld && s_n) state_q <= ARMED;
            end
            ARMED: begin
               if (!s_n) begin
                  low_cnt_q <= LOW_W'(1);
                  state_q   <= (MIN_LOW == 32'd1) ? FIRED : LOW_CNT;
               end
            end
            LOW_CNT: begin
               if (s_n)         state_q   <= ARMED;
               else if (fire_c) state_q   <= FIRED;
               else             low_cnt_q <= low_cnt_q + LOW_W'(1);
            end
            FIRED: begin
               if (s_n) state_q <= ARMED;
            end
            default: state_q <= WAIT_HIGH;
         endcase
      end
   end

   // Per-register write select and revert-counter next value (write wins).
   always_comb begin
      wr_c = '0;
      for (int k = 0; k < NREG; k++) begin
         cnt_nxt[k] = cnt_q[k];
         wr_c[k]    = fire_c && (M68K_ADDR == ADDR_W'(k));
         if (wr_c[k])
            cnt_nxt[k] = CNT_W'(PULSE_CYCLES);
         else if (cnt_q[k] != '0)
            cnt_nxt[k] = cnt_q[k] - CNT_W'(1);
      end
   end

   // Register file, revert counters and status outputs.
   always_ff @(posedge CLK_24M) begin
      if (RESET) begin
         REG_OUT   <= {NREG{RESET_VAL}};
         WR_PULSE  <= '0;
         PULSE_ACT <= '0;
         for (int k = 0; k < NREG; k++) cnt_q[k] <= '0;
      end else begin
         WR_PULSE <= wr_c;
         for (int k = 0; k < NREG; k++) begin
            if (wr_c[k])
               REG_OUT[k*DATA_W +: DATA_W] <= M68K_DATA;
            else if (cnt_q[k] == CNT_W'(1))
               REG_OUT[k*DATA_W +: DATA_W] <= RESET_VAL;
            cnt_q[k]     <= cnt_nxt[k];
            PULSE_ACT[k] <= (cnt_nxt[k] != '0);
         end
      end
   end

endmodule

// File: tb/tb_neo_outlatch.sv
// Testbench for neo_outlatch: a latched instance and a pulse-mode instance
// (PULSE_CYCLES=4) share stimulus; a run-length/timestamp model predicts
// every output after every edge, plus directed constant checks.
module tb_neo_outlatch;

   localparam int unsigned DW   = 6;
   localparam int unsigned AW   = 1;
   localparam int unsigned NR   = 2;
   localparam int unsigned SYN  = 2;
   localparam int unsigned MINL = 2;
   localparam int unsigned PC   = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          nbw;
   logic [AW-1:0] addr;
   logic [DW-1:0] data;

   logic [NR*DW-1:0] lat_out, pls_out;
   logic [NR-1:0]    lat_wr, pls_wr, lat_act, pls_act;

   always #5 clk = ~clk;

   neo_outlatch #(.DATA_W(DW), .ADDR_W(AW), .SYNC_STAGES(SYN), .MIN_LOW(MINL),
                  .PULSE_CYCLES(0), .RESET_VAL('0)) u_lat (
      .CLK_24M(clk), .RESET(rst), .nBITWD(nbw), .M68K_ADDR(addr), .M68K_DATA(data),
      .REG_OUT(lat_out), .WR_PULSE(lat_wr), .PULSE_ACT(lat_act));

   neo_outlatch #(.DATA_W(DW), .ADDR_W(AW), .SYNC_STAGES(SYN), .MIN_LOW(MINL),
                  .PULSE_CYCLES(PC), .RESET_VAL('0)) u_pls (
      .CLK_24M(clk), .RESET(rst), .nBITWD(nbw), .M68K_ADDR(addr), .M68K_DATA(data),
      .REG_OUT(pls_out), .WR_PULSE(pls_wr), .PULSE_ACT(pls_act));

   int checks   = 0;
   int failures = 0;
   int wr_cnt   = 0;
   int edge_n   = 0;

   // Reference model state
   logic          hist[$];
   int            low_run;
   bit            seen_high;
   logic [DW-1:0] m_val [2][NR];
   int            m_wt  [2][NR];
   logic [NR-1:0] m_wr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Model: write fires when a real synchronised low run reaches MIN_LOW
   // after a real high; pulse registers revert PC edges after their last write.
   task automatic model_edge();
      bit fire;
      edge_n++;
      m_wr = '0;
      if (rst) begin
         hist.delete();
         low_run   = 0;
         seen_high = 0;
         for (int m = 0; m < 2; m++)
            for (int k = 0; k < NR; k++) begin
               m_val[m][k] = '0;
               m_wt[m][k]  = -1;
            end
         return;
      end
      fire = 0;
      if (hist.size() == SYN) begin
         if (hist[0]) begin
            low_run   = 0;
            seen_high = 1;
         end else begin
            low_run++;
            fire = seen_high && (low_run == MINL);
         end
      end
      hist.push_back(nbw);
      if (hist.size() > SYN) void'(hist.pop_front());
      for (int m = 0; m < 2; m++) begin
         int pc;
         pc = (m == 1) ? PC : 0;
         for (int k = 0; k < NR; k++) begin
            if (fire && int'(addr) == k) begin
               m_val[m][k] = data;
               m_wt[m][k]  = edge_n;
               m_wr[k]     = 1'b1;
            end else if (pc > 0 && m_wt[m][k] >= 0 && edge_n - m_wt[m][k] >= pc) begin
               m_val[m][k] = '0;
               m_wt[m][k]  = -1;
            end
         end
      end
   endtask

   task automatic tick();
      logic [NR*DW-1:0] e_lat, e_pls;
      logic [NR-1:0]    e_act;
      @(posedge clk);
      model_edge();
      #1;
      for (int k = 0; k < NR; k++) begin
         e_lat[k*DW +: DW] = m_val[0][k];
         e_pls[k*DW +: DW] = m_val[1][k];
         e_act[k]          = (m_wt[1][k] >= 0);
      end
      chk("lat_reg_out", 32'(lat_out), 32'(e_lat));
      chk("pls_reg_out", 32'(pls_out), 32'(e_pls));
      chk("lat_wr_pulse", 32'(lat_wr), 32'(m_wr));
      chk("pls_wr_pulse", 32'(pls_wr), 32'(m_wr));
      chk("lat_pulse_act", 32'(lat_act), 32'd0);
      chk("pls_pulse_act", 32'(pls_act), 32'(e_act));
      if (lat_wr != '0) wr_cnt++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      rst = 1'b1; nbw = 1'b1; addr = '0; data = '0;
      repeat (2) tick();
      chk("reset_reg", 32'(lat_out), 32'd0);
      chk("reset_wr", 32'(pls_wr), 32'd0);
      chk("reset_act", 32'(pls_act), 32'd0);
      rst = 1'b0;
      repeat (4) tick();

      // Reset then write: lands at t0+3
      addr = 1'b1; data = 6'h05; nbw = 1'b0;
      repeat (3) tick();
      chk("t1_before_edge", 32'(lat_out), 32'd0);
      tick();
      chk("t1_value", 32'(lat_out), 32'h140);
      chk("t1_wr_pulse", 32'(lat_wr), 32'b10);
      tick();
      chk("t1_wr_one_clock", 32'(lat_wr), 32'd0);
      tick();
      nbw = 1'b1;
      repeat (6) tick();

      // Glitch rejection, then glitch + 1 high + 6 low gives one write
      addr = 1'b0; data = 6'h11;
      base = wr_cnt;
      nbw = 1'b0; tick(); nbw = 1'b1; repeat (4) tick();
      chk("glitch_no_write", 32'(wr_cnt - base), 32'd0);
      nbw = 1'b0; tick(); nbw = 1'b1; tick();
      nbw = 1'b0; repeat (6) tick(); nbw = 1'b1; repeat (4) tick();
      chk("glitch_then_one", 32'(wr_cnt - base), 32'd1);

      // Long strobe: one write; data change afterwards ignored
      base = wr_cnt;
      addr = 1'b0; data = 6'h2A; nbw = 1'b0;
      repeat (4) tick();
      chk("long_value", 32'(lat_out[5:0]), 32'h2A);
      data = 6'h15;
      repeat (36) tick();
      chk("long_hold", 32'(lat_out[5:0]), 32'h2A);
      nbw = 1'b1; repeat (4) tick();
      chk("long_one_write", 32'(wr_cnt - base), 32'd1);

      // Strobe low across reset release
      nbw = 1'b0; rst = 1'b1; repeat (2) tick(); rst = 1'b0;
      base = wr_cnt;
      repeat (10) tick();
      chk("low_at_release", 32'(wr_cnt - base), 32'd0);
      nbw = 1'b1; repeat (3) tick();
      addr = 1'b1; data = 6'h07; nbw = 1'b0; repeat (6) tick(); nbw = 1'b1; repeat (4) tick();
      chk("after_release_write", 32'(wr_cnt - base), 32'd1);

      // Pulse mode: 3F visible for exactly 4 clocks
      addr = 1'b0; data = 6'h3F; nbw = 1'b0;
      repeat (4) tick();
      for (int i = 0; i < 4; i++) begin
         chk("pulse_value", 32'(pls_out[5:0]), 32'h3F);
         chk("pulse_act", 32'(pls_act[0]), 32'd1);
         tick();
      end
      chk("pulse_revert", 32'(pls_out[5:0]), 32'd0);
      chk("pulse_act_off", 32'(pls_act[0]), 32'd0);
      nbw = 1'b1; repeat (4) tick();

      // Pulse rewrite at tw+3 reloads the counter
      data = 6'h21; nbw = 1'b0; repeat (2) tick();
      nbw = 1'b1; tick();
      nbw = 1'b0; tick();
      chk("rewrite_first", 32'(pls_out[5:0]), 32'h21);
      data = 6'h12;
      repeat (2) tick();
      chk("rewrite_first_held", 32'(pls_out[5:0]), 32'h21);
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("rewrite_value", 32'(pls_out[5:0]), 32'h12);
         chk("rewrite_act", 32'(pls_act[0]), 32'd1);
         tick();
      end
      chk("rewrite_revert", 32'(pls_out[5:0]), 32'd0);
      nbw = 1'b1; repeat (4) tick();

      // Reset on the write edge
      addr = 1'b1; data = 6'h3C; nbw = 1'b0;
      repeat (3) tick();
      rst = 1'b1; tick();
      chk("rst_edge_reg", 32'(lat_out), 32'd0);
      chk("rst_edge_wr", 32'(lat_wr), 32'd0);
      chk("rst_edge_act", 32'(pls_act), 32'd0);
      rst = 1'b0; nbw = 1'b1; repeat (4) tick();

      // Reset during an active pulse
      addr = 1'b1; data = 6'h0F; nbw = 1'b0;
      repeat (5) tick();
      rst = 1'b1; tick();
      chk("rst_pulse_reg", 32'(pls_out), 32'd0);
      chk("rst_pulse_act", 32'(pls_act), 32'd0);
      chk("rst_pulse_wr", 32'(pls_wr), 32'd0);
      rst = 1'b0; nbw = 1'b1; repeat (4) tick();

      // Randomised strobes, lengths and occasional resets
      for (int n = 0; n < 80; n++) begin
         int lo, hi;
         lo   = int'($urandom_range(1, 8));
         hi   = int'($urandom_range(1, 6));
         addr = AW'($urandom_range(0, 1));
         data = DW'($urandom);
         nbw  = 1'b0;
         for (int i = 0; i < lo; i++) begin
            rst = ($urandom_range(0, 29) == 0);
            tick();
         end
         rst = 1'b0;
         nbw = 1'b1;
         repeat (hi) tick();
      end
      repeat (8) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
